dmac_host_driver: RTL and testbench

DMAC_HOST_DRIVER -- requirements
Module: dmac_host_driver

---
 rtl/dmac_host_driver.sv | 145 ++++++++++++++
 tb/tb_dmac_host_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_host_driver.sv
// dmac_host_driver
//   Register-bus host that runs one DMA transfer per accepted command:
//   writes the source address, sets the start bit, polls status every
//   POLL_GAP idle cycles, then reads the end address. A run that does not
//   complete within TIMEOUT_CYCLES is aborted by clearing the start bit.
// Ports
//   iClk, iRstn              clock, asynchronous active-low reset
//   iCmdValid/oCmdReady      command handshake, iCmdSrcAddr = source address
//   o*_Control / iData_Control  register bus (one strobe per access, read
//                            data valid the cycle after the read strobe)
//   oBusy                    run in progress
//   oDone / oTimeout         one-cycle completion / abort pulses
//   oTagFail / oEndAddr      results captured from the final status/end reads
module dmac_host_driver #(
  parameter int unsigned POLL_GAP       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic [31:0] iCmdSrcAddr,
  output logic        oChipSelect_Control,
  output logic        oWrite_Control,
  output logic        oRead_Control,
  output logic [1:0]  oAddress_Control,
  output logic [31:0] oData_Control,
  input  logic [31:0] iData_Control,
  output logic        oBusy,
  output logic        oDone,
  output logic        oTimeout,
  output logic [15:0] oTagFail,
  output logic [31:0] oEndAddr
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_START, GAP, RD_STAT, CAP_STAT, RD_END, CAP_END, ABORT, FINISH
  } state_t;

  localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP - 1);
  localparam logic [19:0] TMO_LIMIT = 20'(TIMEOUT_CYCLES);

  state_t      state, next_state;
  logic [7:0]  gap_cnt;
  logic [19:0] tmo_cnt;
  logic        timed_out;
  logic        stat_done;

  logic        wr_d, rd_d, done_d, tmo_d;
  logic [1:0]  addr_d;
  logic [31:0] data_d;

  assign timed_out = (tmo_cnt >= TMO_LIMIT);
  // done with start already cleared; done+start is a stale previous-run status
  assign stat_done = iData_Control[0] & ~iData_Control[1];

  assign oCmdReady = (state == IDLE);
  assign oBusy     = (state != IDLE);

  // State register, counters, registered bus/result outputs
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state               <= IDLE;
      gap_cnt             <= '0;
      tmo_cnt             <= '0;
      oChipSelect_Control <= 1'b0;
      oWrite_Control      <= 1'b0;
      oRead_Control       <= 1'b0;
      oAddress_Control    <= '0;
      oData_Control       <= '0;
      oDone               <= 1'b0;
      oTimeout            <= 1'b0;
      oTagFail            <= '0;
      oEndAddr            <= '0;
    end else begin
      state               <= next_state;
      oChipSelect_Control <= wr_d | rd_d;
      oWrite_Control      <= wr_d;
      oRead_Control       <= rd_d;
      oAddress_Control    <= addr_d;
      oData_Control       <= data_d;
      oDone               <= done_d;
      oTimeout            <= tmo_d;

      if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
      else              gap_cnt <= '0;

      if (state == WR_START)
        tmo_cnt <= '0;
      else if ((state == GAP || state == RD_STAT || state == CAP_STAT) && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 20'd1;

      if (state == CAP_STAT && !timed_out && stat_done)
        oTagFail <= iData_Control[31:16];
      if (state == CAP_END)
        oEndAddr <= iData_Control;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (iCmdValid) next_state = WR_ADDR;
      WR_ADDR:  next_state = WR_START;
      WR_START: next_state = GAP;
      GAP: begin
        if (timed_out)                next_state = ABORT;
        else if (gap_cnt == GAP_LAST) next_state = RD_STAT;
      end
      // an issued read is always captured before a timeout can abort
      RD_STAT:  next_state = CAP_STAT;
      CAP_STAT: begin
        if (timed_out)      next_state = ABORT;
        else if (stat_done) next_state = RD_END;
        else                next_state = GAP;
      end
      RD_END:   next_state = CAP_END;
      CAP_END:  next_state = FINISH;
      FINISH:   next_state = IDLE;
      ABORT:    next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output logic: decoded from next_state so the strobes come straight from flops
  always_comb begin
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    addr_d = oAddress_Control;
    data_d = oData_Control;
    done_d = (next_state == FINISH);
    tmo_d  = (next_state == ABORT);
    unique case (next_state)
      // WR_ADDR is only entered on accept, so the data register latches the command address
      WR_ADDR:  begin wr_d = 1'b1; addr_d = 2'd0; data_d = iCmdSrcAddr; end
      WR_START: begin wr_d = 1'b1; addr_d = 2'd1; data_d = 32'h1; end
      ABORT:    begin wr_d = 1'b1; addr_d = 2'd1; data_d = '0; end
      RD_STAT:  begin rd_d = 1'b1; addr_d = 2'd2; end
      RD_END:   begin rd_d = 1'b1; addr_d = 2'd3; end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_dmac_host_driver.sv
// tb_dmac_host_driver
//   Directed and randomized runs of dmac_host_driver against a register-file
//   responder and a transaction-level expectation of each run's bus traffic.
module tb_dmac_host_driver;

  localparam int PG  = 4;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        iRstn;
  logic        iCmdValid;
  logic        oCmdReady;
  logic [31:0] iCmdSrcAddr;
  logic        oChipSelect_Control, oWrite_Control, oRead_Control;
  logic [1:0]  oAddress_Control;
  logic [31:0] oData_Control;
  logic [31:0] iData_Control;
  logic        oBusy, oDone, oTimeout;
  logic [15:0] oTagFail;
  logic [31:0] oEndAddr;

  dmac_host_driver #(.POLL_GAP(PG), .TIMEOUT_CYCLES(TMO)) dut (
    .iClk(clk), .iRstn(iRstn), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmdSrcAddr(iCmdSrcAddr), .oChipSelect_Control(oChipSelect_Control),
    .oWrite_Control(oWrite_Control), .oRead_Control(oRead_Control),
    .oAddress_Control(oAddress_Control), .oData_Control(oData_Control),
    .iData_Control(iData_Control), .oBusy(oBusy), .oDone(oDone),
    .oTimeout(oTimeout), .oTagFail(oTagFail), .oEndAddr(oEndAddr)
  );

  always #5 clk = ~clk;

  // ---------------- responder: status script + end address ----------------
  logic [31:0] stat_arr [8];
  int          stat_len = 0;
  logic [31:0] end_val  = '0;
  int          poll_idx = 0;

  always @(posedge clk) begin
    iData_Control <= $urandom;
    if (oWrite_Control && oAddress_Control == 2'd1 && oData_Control == 32'h1) poll_idx <= 0;
    if (oRead_Control && oAddress_Control == 2'd2) begin
      if (poll_idx < stat_len) iData_Control <= stat_arr[poll_idx];
      else                     iData_Control <= $urandom & 32'hFFFF_FFFE;
      poll_idx <= poll_idx + 1;
    end
    if (oRead_Control && oAddress_Control == 2'd3) iData_Control <= end_val;
  end

  // ---------------- bus monitor: access log and protocol checks -----------
  typedef struct { bit is_wr; logic [1:0] addr; logic [31:0] data; int cyc; } acc_t;
  acc_t log_q  [$];
  int   acc_q  [$];
  int   done_q [$];
  int   tmo_q  [$];
  int   cyc = 0;
  int   viol = 0;
  bit   prev_stb = 0, prev_done = 0, prev_tmo = 0;
  logic [1:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (oWrite_Control && oRead_Control) begin viol++; $display("bus violation: two strobes, cycle %0d", cyc); end
    if (oChipSelect_Control !== (oWrite_Control | oRead_Control)) begin viol++; $display("bus violation: chip select, cycle %0d", cyc); end
    if ((oWrite_Control || oRead_Control) && prev_stb && prev_addr == oAddress_Control) begin
      viol++; $display("bus violation: strobe held, cycle %0d", cyc);
    end
    if ((oDone && prev_done) || (oTimeout && prev_tmo) || (oDone && oTimeout)) begin
      viol++; $display("bus violation: pulse shape, cycle %0d", cyc);
    end
    if (oWrite_Control || oRead_Control)
      log_q.push_back('{oWrite_Control, oAddress_Control, oWrite_Control ? oData_Control : 32'h0, cyc});
    if (oDone)    done_q.push_back(cyc);
    if (oTimeout) tmo_q.push_back(cyc);
    if (iRstn && iCmdValid && oCmdReady) acc_q.push_back(cyc);
    prev_stb  = oWrite_Control | oRead_Control;
    prev_addr = oAddress_Control;
    prev_done = oDone;
    prev_tmo  = oTimeout;
  end

  // ---------------- checking ----------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference state
  logic [15:0] exp_tag = '0;
  logic [31:0] exp_end = '0;

  // index of the first genuine done status in the script (-1 if none)
  function automatic int first_done();
    for (int i = 0; i < stat_len; i++)
      if (stat_arr[i][0] == 1'b1 && stat_arr[i][1] == 1'b0) return i;
    return -1;
  endfunction

  // issue one command and wait for its done/timeout pulse
  task automatic issue(input logic [31:0] s, output bit ended);
    iCmdValid = 1'b1; iCmdSrcAddr = s;
    tick(1);
    iCmdValid = 1'b0; iCmdSrcAddr = $urandom;
    ended = 1'b0;
    for (int i = 0; i < 2000 && !ended; i++) begin
      if (oDone || oTimeout) ended = 1'b1;
      else tick(1);
    end
    tick(3);
  endtask

  task automatic run_normal(input string nm, input logic [31:0] s);
    int base, a0, d0, t0, k, n;
    bit ended;
    logic [34:0] exp_q [$];
    base = log_q.size(); a0 = acc_q.size(); d0 = done_q.size(); t0 = tmo_q.size();
    k = first_done();
    exp_q.push_back({1'b1, 2'd0, s});
    exp_q.push_back({1'b1, 2'd1, 32'h1});
    for (int i = 0; i <= k; i++) exp_q.push_back({1'b0, 2'd2, 32'h0});
    exp_q.push_back({1'b0, 2'd3, 32'h0});
    exp_tag = stat_arr[k][31:16];
    exp_end = end_val;
    issue(s, ended);
    chk({nm, "_ended"}, ended, 1'b1);
    n = log_q.size() - base;
    chk({nm, "_n_access"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk({nm, "_access"}, {log_q[base+i].is_wr, log_q[base+i].addr, log_q[base+i].data}, exp_q[i]);
    if (acc_q.size() > a0 && n > 0) chk({nm, "_accept_lat"}, log_q[base].cyc - acc_q[a0], 1);
    for (int i = 0; i <= k && 2 + i < n; i++)
      chk({nm, "_poll_cycle"}, log_q[base+2+i].cyc - log_q[base+1].cyc, PG + 1 + i * (PG + 2));
    chk({nm, "_done_cnt"}, done_q.size() - d0, 1);
    chk({nm, "_tmo_cnt"}, tmo_q.size() - t0, 0);
    chk({nm, "_tag"}, oTagFail, exp_tag);
    chk({nm, "_end"}, oEndAddr, exp_end);
    chk({nm, "_ready"}, oCmdReady, 1'b1);
    chk({nm, "_busy"}, oBusy, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_cs"}, oChipSelect_Control, 1'b0);
    chk({nm, "_wr"}, oWrite_Control, 1'b0);
    chk({nm, "_rd"}, oRead_Control, 1'b0);
    chk({nm, "_addr"}, oAddress_Control, 2'd0);
    chk({nm, "_data"}, oData_Control, 32'h0);
    chk({nm, "_busy"}, oBusy, 1'b0);
    chk({nm, "_done"}, oDone, 1'b0);
    chk({nm, "_tmo"}, oTimeout, 1'b0);
    chk({nm, "_tag"}, oTagFail, 16'h0);
    chk({nm, "_end"}, oEndAddr, 32'h0);
    chk({nm, "_ready"}, oCmdReady, 1'b1);
  endtask

  initial begin
    int base, a0, d0, t0, n, dn, lsz, n_rd3, n_w0;
    bit ended, seen;

    iRstn = 1'b0; iCmdValid = 1'b0; iCmdSrcAddr = '0;
    tick(3);
    chk_all_zero("reset");
    iRstn = 1'b1;
    tick(2);

    // three polls, done on the third
    stat_arr[0] = 32'h0000_0000; stat_arr[1] = 32'h0000_0000; stat_arr[2] = 32'h0005_0001;
    stat_len = 3; end_val = 32'h0000_2000;
    run_normal("basic", 32'h0000_1000);
    chk("basic_tag5", oTagFail, 16'd5);

    // stale done on first poll must not complete the run
    stat_arr[0] = 32'h0000_0003; stat_arr[1] = 32'h0000_0001;
    stat_len = 2; end_val = 32'h0000_3344;
    run_normal("stale", 32'h0000_5000);

    // randomized scripts mixing not-done, stale-done and one final done
    for (int r = 0; r < 6; r++) begin
      stat_len = $urandom_range(1, 6);
      for (int i = 0; i < stat_len - 1; i++)
        stat_arr[i] = ($urandom_range(0, 1) != 0) ? ($urandom | 32'h3) : ($urandom & 32'hFFFF_FFFE);
      stat_arr[stat_len-1] = ($urandom & 32'hFFFF_FFFC) | 32'h1;
      end_val = $urandom;
      run_normal("rand", $urandom);
    end

    // no done ever -> abort write and timeout pulse, results untouched
    stat_len = 0;
    base = log_q.size(); d0 = done_q.size(); t0 = tmo_q.size();
    issue(32'hDEAD_0000, ended);
    chk("tmo_ended", ended, 1'b1);
    n = log_q.size() - base;
    n_rd3 = 0;
    for (int i = 0; i < n; i++) if (!log_q[base+i].is_wr && log_q[base+i].addr == 2'd3) n_rd3++;
    chk("tmo_no_end_read", n_rd3, 0);
    if (n >= 3) begin
      chk("tmo_first_wr", {log_q[base].is_wr, log_q[base].addr, log_q[base].data}, {1'b1, 2'd0, 32'hDEAD_0000});
      chk("tmo_abort_wr", {log_q[base+n-1].is_wr, log_q[base+n-1].addr, log_q[base+n-1].data}, {1'b1, 2'd1, 32'h0});
      seen = (log_q[base+n-1].cyc - log_q[base+1].cyc >= TMO) && (log_q[base+n-1].cyc - log_q[base+1].cyc <= TMO + PG + 4);
      chk("tmo_abort_window", seen, 1'b1);
    end else chk("tmo_n_access", n >= 3, 1'b1);
    chk("tmo_pulse_cnt", tmo_q.size() - t0, 1);
    chk("tmo_done_cnt", done_q.size() - d0, 0);
    chk("tmo_tag", oTagFail, exp_tag);
    chk("tmo_end", oEndAddr, exp_end);
    chk("tmo_ready", oCmdReady, 1'b1);

    // command held valid through two runs: no queuing, second accept after first done
    stat_arr[0] = 32'h0007_0001; stat_len = 1; end_val = 32'h0000_7777;
    base = log_q.size(); a0 = acc_q.size(); d0 = done_q.size();
    iCmdValid = 1'b1; iCmdSrcAddr = 32'h0000_9000;
    dn = 0;
    for (int i = 0; i < 1000 && dn < 2; i++) begin
      tick(1);
      if (oDone) dn++;
    end
    iCmdValid = 1'b0;
    tick(4);
    chk("hold_done_pulses", dn, 2);
    n_w0 = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].is_wr && log_q[i].addr == 2'd0) n_w0++;
    chk("hold_addr_writes", n_w0, 2);
    chk("hold_accepts", acc_q.size() - a0, 2);
    if (acc_q.size() - a0 >= 2 && done_q.size() > d0)
      chk("hold_second_after_done", acc_q[a0+1] > done_q[d0], 1'b1);
    exp_tag = 16'h0007; exp_end = 32'h0000_7777;
    chk("hold_tag", oTagFail, exp_tag);
    chk("hold_end", oEndAddr, exp_end);

    // reset pulsed during the poll gap
    stat_arr[0] = 32'h0009_0001; stat_len = 1;
    iCmdValid = 1'b1; iCmdSrcAddr = 32'h0000_A000;
    tick(1);
    iCmdValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (oWrite_Control && oAddress_Control == 2'd1) seen = 1'b1;
      else tick(1);
    end
    chk("rst_saw_start", seen, 1'b1);
    tick(2);
    iRstn = 1'b0;
    #1;
    exp_tag = '0; exp_end = '0;
    chk_all_zero("rst_mid");
    lsz = log_q.size();
    tick(3);
    chk("rst_no_strobes", log_q.size(), lsz);
    iRstn = 1'b1;
    tick(1);
    chk("rst_ready_after", oCmdReady, 1'b1);
    chk("rst_quiet_after", log_q.size(), lsz);
    end_val = 32'h0000_BEEF;
    run_normal("post_rst", 32'h0000_C000);

    chk("bus_protocol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
